// File: rtl/nibble_serial_add_ctrl.sv
// Two-requester front end for a shared 4-bit adder slice: wide operands are
// summed one nibble per cycle, LSB first, and returned on a valid/ready port.
module nibble_serial_add_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         req1_ready,
    output logic         res_valid,
    output logic [W-1:0] res_sum,
    output logic         res_cout,
    output logic         res_id,
    input  logic         res_ready
);

    localparam int KW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    a_q, b_q;
    logic            carry_q;
    logic [KW-1:0]   k_q;
    logic [3:0]      nib_a_q, nib_b_q;
    logic            nib_vld_q, nib_last_q;
    logic [W-1:0]    res_sum_q;
    logic            res_cout_q, res_id_q, res_valid_q;
    logic            last_grant_q;

    logic            grant0, grant1;
    logic [4:0]      slice_d;

    always_comb begin
        grant0  = (state_q == IDLE) && req0_valid && (!req1_valid || last_grant_q);
        grant1  = (state_q == IDLE) && req1_valid && (!req0_valid || !last_grant_q);
        slice_d = {1'b0, nib_a_q} + {1'b0, nib_b_q} + {4'b0000, carry_q};
    end

    // Nibbles are staged through nib_*_q one cycle ahead of the slice, so the
    // operand shift and the carry-dependent add never share a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            carry_q      <= 1'b0;
            k_q          <= '0;
            nib_vld_q    <= 1'b0;
            nib_last_q   <= 1'b0;
            res_sum_q    <= '0;
            res_cout_q   <= 1'b0;
            res_id_q     <= 1'b0;
            res_valid_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_q          <= grant1 ? req1_a   : req0_a;
                        b_q          <= grant1 ? req1_b   : req0_b;
                        carry_q      <= grant1 ? req1_cin : req0_cin;
                        res_id_q     <= grant1;
                        last_grant_q <= grant1;
                        k_q          <= '0;
                        nib_vld_q    <= 1'b0;
                        nib_last_q   <= 1'b0;
                        state_q      <= ADD;
                    end
                end
                ADD: begin
                    nib_vld_q <= (k_q != KW'(NIBBLES));
                    if (k_q != KW'(NIBBLES)) begin
                        nib_a_q    <= a_q[3:0];
                        nib_b_q    <= b_q[3:0];
                        a_q        <= a_q >> 4;
                        b_q        <= b_q >> 4;
                        nib_last_q <= (k_q == KW'(NIBBLES - 1));
                        k_q        <= k_q + 1'b1;
                    end
                    // The sum shifts in from the top, so after the last nibble
                    // every slot holds its own nibble of the result.
                    if (nib_vld_q) begin
                        res_sum_q <= (res_sum_q >> 4) | (W'(slice_d[3:0]) << (W - 4));
                        carry_q   <= slice_d[4];
                        if (nib_last_q) begin
                            res_cout_q  <= slice_d[4];
                            res_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = res_valid_q;
    assign res_sum    = res_sum_q;
    assign res_cout   = res_cout_q;
    assign res_id     = res_id_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed and randomized bench for nibble_serial_add_ctrl (16-bit and 4-bit builds),
// checked against plain-arithmetic expectations and a cycle-count timing model.
module tb_nibble_serial_add_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_cin = 1'b0, req1_cin = 1'b0;
    logic         req0_ready, req1_ready;
    logic         res_valid, res_cout, res_id;
    logic [W-1:0] res_sum;
    logic         res_ready = 1'b1;

    logic         d1_req0_valid = 1'b0, d1_req1_valid = 1'b0;
    logic [3:0]   d1_req0_a = '0, d1_req0_b = '0, d1_req1_a = '0, d1_req1_b = '0;
    logic         d1_req0_cin = 1'b0, d1_req1_cin = 1'b0;
    logic         d1_req0_ready, d1_req1_ready;
    logic         d1_res_valid, d1_res_cout, d1_res_id;
    logic [3:0]   d1_res_sum;
    logic         d1_res_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .req1_ready(req1_ready),
        .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
        .res_ready(res_ready)
    );

    nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(d1_req0_valid), .req0_a(d1_req0_a), .req0_b(d1_req0_b), .req0_cin(d1_req0_cin),
        .req0_ready(d1_req0_ready),
        .req1_valid(d1_req1_valid), .req1_a(d1_req1_a), .req1_b(d1_req1_b), .req1_cin(d1_req1_cin),
        .req1_ready(d1_req1_ready),
        .res_valid(d1_res_valid), .res_sum(d1_res_sum), .res_cout(d1_res_cout), .res_id(d1_res_id),
        .res_ready(d1_res_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit id, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin);
        if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin; end
        else    begin req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin; end
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk); #1;
            lat++;
        end
    endtask

    // One isolated operation on the 16-bit build, with res_ready held high.
    task automatic do_op(input string tag, input bit id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin,
                         input logic [W:0] expd);
        int lat;
        drive(id, 1'b1, a, b, cin);
        res_ready = 1'b1;
        #1;
        chk({tag, "_rdy0"}, 64'(req0_ready), 64'(!id));
        chk({tag, "_rdy1"}, 64'(req1_ready), 64'(id));
        @(negedge clk);
        drive(id, 1'b0, '0, '0, 1'b0);
        #1;
        wait_res(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(N + 1));
        chk({tag, "_sum"}, 64'({res_cout, res_sum}), 64'(expd));
        chk({tag, "_id"}, 64'(res_id), 64'(id));
        @(negedge clk); #1;
        chk({tag, "_vld_drop"}, 64'(res_valid), 64'(0));
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    endfunction

    initial begin
        int          lat, n, ops, cyc, m_cnt;
        bit          m_idle, m_done, m_last, seen, v0, v1, e0, e1;
        logic [W-1:0] ra, rb, hold_sum;
        logic        rc, hold_cout;
        logic [W+1:0] q[$];
        logic [W+1:0] front;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(res_valid), 64'(0));
        chk("rst_sum", 64'(res_sum), 64'(0));
        chk("rst_cout", 64'(res_cout), 64'(0));
        chk("rst_id", 64'(res_id), 64'(0));
        chk("rst_rdy", 64'({req0_ready, req1_ready}), 64'(0));

        do_op("ripple", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 17'h1_0000);
        do_op("cin_req1", 1'b1, 16'h1234, 16'h4321, 1'b1, 17'h0_5556);

        // Both requesters valid from reset: grants alternate starting with 0
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        drive(1'b0, 1'b1, 16'h00FF, 16'h0F01, 1'b1);
        drive(1'b1, 1'b1, 16'hA5A5, 16'h5A5B, 1'b0);
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(req0_ready || req1_ready) && n < 40) begin
                @(negedge clk); #1;
                n++;
            end
            chk("alt_wait", 64'(n < 40), 64'(1));
            chk("alt_winner", 64'({req1_ready, req0_ready}), 64'((g % 2) ? 2 : 1));
            @(negedge clk); #1;
            chk("alt_pulse", 64'({req0_ready, req1_ready}), 64'(0));
            wait_res(lat);
            chk("alt_id", 64'(res_id), 64'(g % 2));
            chk("alt_sum", 64'({res_cout, res_sum}),
                64'((g % 2) ? ref_add(16'hA5A5, 16'h5A5B, 1'b0) : ref_add(16'h00FF, 16'h0F01, 1'b1)));
            @(negedge clk); #1;
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);

        // Backpressure in DONE
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        drive(1'b0, 1'b1, ra, rb, rc);
        res_ready = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        #1;
        wait_res(lat);
        chk("bp_sum", 64'({res_cout, res_sum}), 64'(ref_add(ra, rb, rc)));
        hold_sum = res_sum; hold_cout = res_cout;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        drive(1'b0, 1'b1, ra, rb, rc);
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_vld", 64'(res_valid), 64'(1));
            chk("bp_hold_res", 64'({res_cout, res_sum}), 64'({hold_cout, hold_sum}));
            chk("bp_rdy0", 64'(req0_ready), 64'(0));
            @(negedge clk); #1;
        end
        res_ready = 1'b1;
        #1;
        @(negedge clk); #1;
        chk("bp_release_vld", 64'(res_valid), 64'(0));
        chk("bp_next_accept", 64'(req0_ready), 64'(1));
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        #1;
        wait_res(lat);
        chk("bp_next_lat", 64'(lat), 64'(N + 1));
        chk("bp_next_sum", 64'({res_cout, res_sum}), 64'(ref_add(ra, rb, rc)));
        @(negedge clk);

        // Reset after nibble 1 discards the operation
        drive(1'b1, 1'b1, 16'h7777, 16'h8889, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(res_valid), 64'(0));
        chk("mid_rst_sum", 64'(res_sum), 64'(0));
        chk("mid_rst_cout", 64'(res_cout), 64'(0));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        chk("mid_rst_no_stale", 64'(seen), 64'(0));
        drive(1'b0, 1'b1, 16'h0102, 16'h0304, 1'b0);
        drive(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0);
        #1;
        chk("mid_rst_tie", 64'({req1_ready, req0_ready}), 64'(1));
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        #1;
        wait_res(lat);
        chk("mid_rst_res", 64'({res_id, res_cout, res_sum}), 64'({1'b0, ref_add(16'h0102, 16'h0304, 1'b0)}));
        @(negedge clk);

        // Random traffic against a timing model: accept in IDLE, result N+1 edges later
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        m_idle = 1'b1; m_done = 1'b0; m_last = 1'b1; m_cnt = 0;
        ops = 0; cyc = 0;
        while (ops < 1000 && cyc < 40000) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            drive(1'b0, v0, 16'($urandom), 16'($urandom), 1'($urandom));
            drive(1'b1, v1, 16'($urandom), 16'($urandom), 1'($urandom));
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            e0 = m_idle && v0 && (!v1 || m_last);
            e1 = m_idle && v1 && (!v0 || !m_last);
            chk("rnd_rdy", 64'({req1_ready, req0_ready}), 64'({e1, e0}));
            chk("rnd_vld", 64'(res_valid), 64'(m_done));
            if (m_done && q.size() > 0) begin
                front = q[0];
                chk("rnd_res", 64'({res_id, res_cout, res_sum}), 64'(front));
            end
            if (e0 || e1) begin
                q.push_back(e1 ? {1'b1, ref_add(req1_a, req1_b, req1_cin)}
                               : {1'b0, ref_add(req0_a, req0_b, req0_cin)});
                m_last = e1; m_idle = 1'b0; m_cnt = N + 1;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_done = 1'b1;
            end else if (m_done && res_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                m_done = 1'b0; m_idle = 1'b1; ops++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rnd_ops_done", 64'(ops), 64'(1000));
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        res_ready = 1'b1;

        // Single-nibble build: latency 2
        for (int i = 0; i < 20; i++) begin
            logic [3:0] a1, b1;
            logic       c1;
            bit         id1;
            logic [4:0] e;
            a1 = 4'($urandom); b1 = 4'($urandom); c1 = 1'($urandom); id1 = 1'(i % 2);
            e = 5'(a1) + 5'(b1) + 5'(c1);
            if (id1) begin d1_req1_valid = 1'b1; d1_req1_a = a1; d1_req1_b = b1; d1_req1_cin = c1; end
            else     begin d1_req0_valid = 1'b1; d1_req0_a = a1; d1_req0_b = b1; d1_req0_cin = c1; end
            #1;
            chk("n1_rdy", 64'({d1_req1_ready, d1_req0_ready}), 64'(id1 ? 2 : 1));
            @(negedge clk);
            d1_req0_valid = 1'b0; d1_req1_valid = 1'b0;
            #1;
            lat = 0;
            while (!d1_res_valid && lat < 20) begin
                @(negedge clk); #1;
                lat++;
            end
            chk("n1_lat", 64'(lat), 64'(2));
            chk("n1_res", 64'({d1_res_id, d1_res_cout, d1_res_sum}), 64'({id1, e}));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
